// File: rtl/seq_cla_adder64_pkg.sv
// Shared constants and FSM state encoding for the sequential CLA adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_SLICE = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_cla_adder64_cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder built from 4-bit P/G groups.
module cla_slice #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  localparam int unsigned NG = SLICE / 4;

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;

  always_comb begin
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    grp_p = '0;
    grp_g = '0;
    c[0]  = ci;
    // Bit carries inside a group come from the group carry-in; the next group carry uses group P/G.
    for (int unsigned i = 0; i < NG; i++) begin
      grp_p[i] = &p[4*i +: 4];
      grp_g[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
      c[4*i+2] = g[4*i+1]
               | (p[4*i+1] & g[4*i])
               | (p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+3] = g[4*i+2]
               | (p[4*i+2] & g[4*i+1])
               | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+4] = grp_g[i] | (grp_p[i] & c[4*i]);
    end
    s  = p ^ c[SLICE-1:0];
    co = c[SLICE];
  end

endmodule

// File: rtl/seq_cla_adder64.sv
// Multi-cycle WIDTH-bit adder: one SLICE-bit CLA segment per clock behind ready/valid.
module seq_cla_adder64
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;

  int unsigned      base;
  logic [SLICE-1:0] seg_a;
  logic [SLICE-1:0] seg_b;
  logic [SLICE-1:0] seg_s;
  logic             seg_co;

  always_comb begin
    base  = 32'(idx) * SLICE;
    seg_a = a_q[base +: SLICE];
    seg_b = b_q[base +: SLICE];
  end

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a  (seg_a),
    .b  (seg_b),
    .ci (carry_q),
    .s  (seg_s),
    .co (seg_co)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            carry_q  <= cin;
            idx      <= '0;
            sum      <= '0;
            in_ready <= 1'b0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          sum[base +: SLICE] <= seg_s;
          carry_q            <= seg_co;
          if (idx == IDXW'(NSLICE - 1)) begin
            cout      <= seg_co;
            ovf       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (seg_s[SLICE-1] != a_q[WIDTH-1]);
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_cla_adder64.sv
// Self-checking bench: latency/handshake model plus 65-bit arithmetic reference.
module tb_seq_cla_adder64;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned SLICE  = 16;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  seq_cla_adder64 #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the operation is accepted when idle, the result appears NSLICE edges later.
  logic             m_ok = 1'b0;
  logic             m_ready = 1'b0;
  logic             m_valid = 1'b0;
  logic             m_clear = 1'b0;
  int               m_cnt = 0;
  int               m_done = 0;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf = 1'b0;
  logic [WIDTH:0]   m_full;

  always @(posedge CLK) begin
    if (reset) begin
      m_ok    = 1'b1;
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_clear = 1'b1;
      m_cnt   = 0;
    end else if (m_ok) begin
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0;
          m_ready = 1'b1;
          m_done++;
        end
      end else if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) m_valid = 1'b1;
      end else if (m_ready && in_valid) begin
        m_full  = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, cin};
        m_sum   = m_full[WIDTH-1:0];
        m_cout  = m_full[WIDTH];
        m_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (m_full[WIDTH-1] != in_a[WIDTH-1]);
        m_cnt   = NSLICE;
        m_ready = 1'b0;
        m_clear = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_ok) begin
      check("in_ready", {127'd0, in_ready}, {127'd0, m_ready});
      check("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
      if (m_valid) begin
        check("sum", {64'd0, sum}, {64'd0, m_sum});
        check("cout", {127'd0, cout}, {127'd0, m_cout});
        check("ovf", {127'd0, ovf}, {127'd0, m_ovf});
      end else if (m_clear) begin
        check("sum_after_reset", {63'd0, ovf, cout, sum}, 128'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("ready_timeout", {127'd0, in_ready}, 128'd1);
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    wait_ready();
    in_a      = a;
    in_b      = b;
    cin       = c;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge CLK);
    in_valid = 1'b0;
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
    cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int lat = 0;
    start_op(a, b, c);
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(NSLICE));
    check({name, "_sum"}, {64'd0, sum}, {64'd0, es});
    check({name, "_cout"}, {127'd0, cout}, {127'd0, ec});
    check({name, "_ovf"}, {127'd0, ovf}, {127'd0, eo});
    check({name, "_model"}, {62'd0, m_ovf, m_cout, m_sum}, {62'd0, eo, ec, es});
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check({name, "_ready_after"}, {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    int target;
    int guard;

    repeat (2) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("reset_state", {61'd0, in_ready, out_valid, ovf, cout, sum}, {61'd0, 1'b1, 3'b000, 64'd0});

    run_op("zero", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    release_result("zero");

    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
    release_result("ripple");

    run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    release_result("sovf");

    run_op("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1);
    release_result("negovf");

    // Back-pressure: result must stay put and no new operand may be accepted.
    run_op("bp", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1,
           64'h0000_0000_0000_0000, 1'b1, 1'b0);
    held     = sum;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_stable", {62'd0, out_valid, in_ready, sum}, {62'd0, 1'b1, 1'b0, held});
    end
    in_valid = 1'b0;
    release_result("bp");

    // Reset while the third slice is pending.
    start_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("midreset", {61'd0, in_ready, out_valid, ovf, cout, sum}, {61'd0, 1'b1, 3'b000, 64'd0});
    reset = 1'b0;
    run_op("after_reset", 64'd5, 64'd7, 1'b1, 64'd13, 1'b0, 1'b0);
    release_result("after_reset");

    // Randomized back-to-back traffic with occasional consumer stalls.
    target = m_done + 500;
    guard  = 0;
    while (m_done < target && guard < 6000) begin
      case ($urandom_range(0, 7))
        0:       in_a = '1;
        1:       in_a = 64'h7FFF_FFFF_FFFF_FFFF;
        default: in_a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0:       in_b = '0;
        1:       in_b = 64'h8000_0000_0000_0000;
        default: in_b = {$urandom, $urandom};
      endcase
      cin       = 1'($urandom_range(0, 1));
      in_valid  = 1'b1;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      guard++;
    end
    check("random_ops_done", 128'(m_done >= target), 128'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (NSLICE + 3) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
